// File: rtl/mem_stage_param.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_param
// Purpose  : Parametrised memory stage of the pipelined processor. Holds the
//            data memory and the MEM/WB register, selects the write-back
//            source (memory word or ALU result), supports a configurable
//            load latency with a stall handshake and flags out-of-range
//            accesses.
// Ports    :
//   clk            in   rising-edge clock
//   rst_n          in   asynchronous active-low reset
//   in_valid       in   EX/MEM holds a valid instruction
//   mem_read       in   load
//   mem_write      in   store (wins over mem_read when both are set)
//   mem_to_reg     in   1: write back memory word, 0: write back alu_data
//   addr           in   [ADDR_W-1:0] memory word address
//   write_data     in   [DATA_W-1:0] store data
//   alu_data       in   [DATA_W-1:0] ALU result
//   rd_in          in   [REG_W-1:0]  destination register
//   reg_write_in   in   register-file write enable
//   stall          out  stage busy, upstream must hold its inputs
//   wb_valid       out  write-back outputs valid this cycle
//   wb_data        out  [DATA_W-1:0] write-back data
//   wb_rd          out  [REG_W-1:0]  destination register
//   wb_reg_write   out  register-file write enable, qualified by wb_valid
//   addr_err       out  one-cycle pulse with wb_valid of an out-of-range access
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage_param #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 16,
    parameter int DEPTH    = 4096,
    parameter int READ_LAT = 1,
    parameter int REG_W    = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              mem_to_reg,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] write_data,
    input  logic [DATA_W-1:0] alu_data,
    input  logic [REG_W-1:0]  rd_in,
    input  logic              reg_write_in,
    output logic              stall,
    output logic              wb_valid,
    output logic [DATA_W-1:0] wb_data,
    output logic [REG_W-1:0]  wb_rd,
    output logic              wb_reg_write,
    output logic              addr_err
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int              c_idx_w      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so that DEPTH == 2**ADDR_W is still representable.
    localparam logic [ADDR_W:0] c_depth      = (ADDR_W + 1)'(DEPTH);
    localparam logic [2:0]      c_lat_m1     = 3'(READ_LAT - 1);
    localparam bit              c_multi_lat  = (READ_LAT > 1);

    localparam logic [0:0]      S_IDLE       = 1'b0;
    localparam logic [0:0]      S_WAIT       = 1'b1;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [DATA_W-1:0]  r_mem [0:DEPTH-1];

    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;
    logic [2:0]         r_cnt;

    // Instruction captured while a multi-cycle load is in flight.
    logic [c_idx_w-1:0] r_lat_idx;
    logic               r_lat_in_range;
    logic               r_lat_m2r;
    logic [DATA_W-1:0]  r_lat_alu;
    logic [REG_W-1:0]   r_lat_rd;
    logic               r_lat_rw;

    // MEM/WB register
    logic               r_wb_valid;
    logic [DATA_W-1:0]  r_wb_data;
    logic [REG_W-1:0]   r_wb_rd;
    logic               r_wb_reg_write;
    logic               r_addr_err;

    // ------------------------------------------------------------------
    // Combinational decode of the presented instruction
    // ------------------------------------------------------------------
    logic               w_stall;
    logic               w_accept;
    logic               w_in_range;
    logic [c_idx_w-1:0] w_idx;
    logic               w_is_mem;
    logic               w_slow_load;
    logic               w_do_store;
    logic               w_lat_done;
    logic [DATA_W-1:0]  w_rd_word;
    logic [DATA_W-1:0]  w_wb_now;
    logic [DATA_W-1:0]  w_lat_word;
    logic [DATA_W-1:0]  w_wb_lat;

    assign w_accept    = in_valid & ~w_stall;
    assign w_in_range  = ({1'b0, addr} < c_depth);
    assign w_idx       = addr[c_idx_w-1:0];
    assign w_is_mem    = mem_read | mem_write;
    // A simultaneous read+write is a plain store and never takes the long path.
    assign w_slow_load = c_multi_lat & mem_read & ~mem_write;
    assign w_do_store  = w_accept & mem_write & w_in_range;
    assign w_lat_done  = (r_state == S_WAIT) && (r_cnt == 3'd1);

    // Out-of-range reads return zero instead of aliasing onto a legal word.
    // The read happens before the accepting edge, so a store returns the
    // previous contents when mem_to_reg is also set.
    assign w_rd_word   = w_in_range ? r_mem[w_idx] : '0;
    assign w_wb_now    = mem_to_reg ? w_rd_word : alu_data;

    // Memory cannot change while in WAIT (inputs are ignored), so reading the
    // latched address at the end is equivalent to reading it at acceptance.
    assign w_lat_word  = r_lat_in_range ? r_mem[r_lat_idx] : '0;
    assign w_wb_lat    = r_lat_m2r ? w_lat_word : r_lat_alu;

    // ------------------------------------------------------------------
    // Data memory (contents deliberately survive reset)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_do_store) begin
            r_mem[w_idx] <= write_data;
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept && w_slow_load) begin
                r_cnt <= c_lat_m1;
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt - 3'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept && w_slow_load) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt == 3'd1) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_stall = 1'b0;
        case (r_state)
            S_WAIT:  w_stall = 1'b1;
            default: w_stall = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Latch of the pending multi-cycle load
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lat_idx      <= '0;
            r_lat_in_range <= 1'b0;
            r_lat_m2r      <= 1'b0;
            r_lat_alu      <= '0;
            r_lat_rd       <= '0;
            r_lat_rw       <= 1'b0;
        end else if (w_accept && w_slow_load) begin
            r_lat_idx      <= w_idx;
            r_lat_in_range <= w_in_range;
            r_lat_m2r      <= mem_to_reg;
            r_lat_alu      <= alu_data;
            r_lat_rd       <= rd_in;
            r_lat_rw       <= reg_write_in;
        end
    end

    // ------------------------------------------------------------------
    // MEM/WB register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wb_valid     <= 1'b0;
            r_wb_data      <= '0;
            r_wb_rd        <= '0;
            r_wb_reg_write <= 1'b0;
            r_addr_err     <= 1'b0;
        end else begin
            // Strobes default low; data and destination hold when idle.
            r_wb_valid     <= 1'b0;
            r_wb_reg_write <= 1'b0;
            r_addr_err     <= 1'b0;
            if (w_accept && !w_slow_load) begin
                r_wb_valid     <= 1'b1;
                r_wb_data      <= w_wb_now;
                r_wb_rd        <= rd_in;
                r_wb_reg_write <= reg_write_in;
                r_addr_err     <= w_is_mem & ~w_in_range;
            end else if (w_lat_done) begin
                r_wb_valid     <= 1'b1;
                r_wb_data      <= w_wb_lat;
                r_wb_rd        <= r_lat_rd;
                r_wb_reg_write <= r_lat_rw;
                // The long path is only ever taken by loads.
                r_addr_err     <= ~r_lat_in_range;
            end
        end
    end

    assign stall        = w_stall;
    assign wb_valid     = r_wb_valid;
    assign wb_data      = r_wb_data;
    assign wb_rd        = r_wb_rd;
    assign wb_reg_write = r_wb_reg_write;
    assign addr_err     = r_addr_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_stage_param
// Purpose  : Self-checking bench for mem_stage_param. Two instances are
//            exercised (load latency 1 and 3) against a transaction-level
//            model: each accepted instruction produces one expected result
//            scheduled at an absolute cycle, and the stage is expected busy
//            until that cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stage_param;

    typedef struct packed {
        logic        valid;
        logic        rd;
        logic        wr;
        logic        m2r;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] alu;
        logic [2:0]  rdst;
        logic        rw;
    } instr_t;

    logic   clk = 1'b0;
    logic   rst_n = 1'b1;
    instr_t ins0 = '0;
    instr_t ins1 = '0;

    logic        stall0, wb_valid0, wb_reg_write0, addr_err0;
    logic [15:0] wb_data0;
    logic [2:0]  wb_rd0;
    logic        stall1, wb_valid1, wb_reg_write1, addr_err1;
    logic [15:0] wb_data1;
    logic [2:0]  wb_rd1;

    always #5 clk = ~clk;

    mem_stage_param #(.READ_LAT(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(ins0.valid), .mem_read(ins0.rd),
        .mem_write(ins0.wr), .mem_to_reg(ins0.m2r), .addr(ins0.addr),
        .write_data(ins0.wdata), .alu_data(ins0.alu), .rd_in(ins0.rdst),
        .reg_write_in(ins0.rw), .stall(stall0), .wb_valid(wb_valid0),
        .wb_data(wb_data0), .wb_rd(wb_rd0), .wb_reg_write(wb_reg_write0),
        .addr_err(addr_err0)
    );

    mem_stage_param #(.READ_LAT(3)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(ins1.valid), .mem_read(ins1.rd),
        .mem_write(ins1.wr), .mem_to_reg(ins1.m2r), .addr(ins1.addr),
        .write_data(ins1.wdata), .alu_data(ins1.alu), .rd_in(ins1.rdst),
        .reg_write_in(ins1.rw), .stall(stall1), .wb_valid(wb_valid1),
        .wb_data(wb_data1), .wb_rd(wb_rd1), .wb_reg_write(wb_reg_write1),
        .addr_err(addr_err1)
    );

    // ------------------------------------------------------------------
    // Reference model state
    // ------------------------------------------------------------------
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          free_at  [2];
    int          due_at   [2];
    logic [15:0] pend_data[2];
    logic [2:0]  pend_rd  [2];
    logic        pend_rw  [2];
    logic        pend_err [2];
    logic [15:0] last_data[2];
    logic [2:0]  last_rd  [2];
    logic [15:0] mdl_mem  [2][4096];
    bit          last_acc;

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic check_stall(input int k);
        logic st;
        st = (k == 0) ? stall0 : stall1;
        check($sformatf("d%0d_stall", k), {31'd0, st}, {31'd0, (cyc < free_at[k])});
    endtask

    task automatic check_outputs(input int k);
        logic        v, rw, er, ev;
        logic [15:0] dat;
        logic [2:0]  r;
        if (k == 0) begin
            v = wb_valid0; rw = wb_reg_write0; er = addr_err0; dat = wb_data0; r = wb_rd0;
        end else begin
            v = wb_valid1; rw = wb_reg_write1; er = addr_err1; dat = wb_data1; r = wb_rd1;
        end
        ev = (cyc == due_at[k]);
        if (ev) begin
            last_data[k] = pend_data[k];
            last_rd[k]   = pend_rd[k];
        end
        check($sformatf("d%0d_wb_valid", k), {31'd0, v}, {31'd0, ev});
        check($sformatf("d%0d_wb_data", k), {16'd0, dat}, {16'd0, last_data[k]});
        check($sformatf("d%0d_wb_rd", k), {29'd0, r}, {29'd0, last_rd[k]});
        check($sformatf("d%0d_wb_reg_write", k), {31'd0, rw}, {31'd0, ev & pend_rw[k]});
        check($sformatf("d%0d_addr_err", k), {31'd0, er}, {31'd0, ev & pend_err[k]});
    endtask

    // One clock cycle: present x to DUT d (the other sees idle), model the
    // acceptance, advance one edge and compare both instances.
    task automatic step(input int d, input instr_t x);
        logic        exp_stall, in_rng;
        logic [15:0] word;
        int          lat;
        if (d == 0) begin ins0 = x; ins1 = '0; end
        else        begin ins1 = x; ins0 = '0; end
        #1;
        check_stall(0);
        check_stall(1);
        exp_stall = (cyc < free_at[d]);
        last_acc  = x.valid && !exp_stall;
        if (last_acc) begin
            in_rng       = (x.addr < 16'd4096);
            word         = in_rng ? mdl_mem[d][x.addr[11:0]] : 16'h0000;
            lat          = (x.rd && !x.wr) ? lat_of(d) : 1;
            due_at[d]    = cyc + lat;
            free_at[d]   = cyc + lat;
            pend_data[d] = x.m2r ? word : x.alu;
            pend_rd[d]   = x.rdst;
            pend_rw[d]   = x.rw;
            pend_err[d]  = !in_rng && (x.rd || x.wr);
            if (x.wr && in_rng) mdl_mem[d][x.addr[11:0]] = x.wdata;
        end
        @(negedge clk);
        cyc++;
        check_outputs(0);
        check_outputs(1);
    endtask

    // Hold x until the stage takes it.
    task automatic issue(input int d, input instr_t x);
        for (int i = 0; i < 8; i++) begin
            step(d, x);
            if (last_acc) return;
        end
        n_checks++;
        n_fail++;
        $display("FAIL d%0d_issue_timeout: got=not_accepted exp=accepted (cycle %0d)", d, cyc);
    endtask

    function automatic instr_t mk(input logic rd, input logic wr, input logic m2r,
                                  input logic [15:0] a, input logic [15:0] wd,
                                  input logic [15:0] alu, input logic [2:0] rdst,
                                  input logic rw);
        instr_t x;
        x.valid = 1'b1; x.rd = rd; x.wr = wr; x.m2r = m2r; x.addr = a;
        x.wdata = wd; x.alu = alu; x.rdst = rdst; x.rw = rw;
        return x;
    endfunction

    function automatic instr_t rand_instr();
        instr_t x;
        int     op, ap;
        op      = int'($urandom_range(0, 3));
        ap      = int'($urandom_range(0, 9));
        x.valid = ($urandom_range(0, 7) != 0);
        x.rd    = (op == 1) || (op == 3);
        x.wr    = (op == 2) || (op == 3);
        x.m2r   = x.wr ? 1'b0 : 1'($urandom_range(0, 1));
        if (ap < 7)       x.addr = 16'($urandom_range(0, 63));
        else if (ap == 7) x.addr = 16'h0FFF;
        else if (ap == 8) x.addr = 16'h1000;
        else              x.addr = 16'($urandom_range(32'h1001, 32'hFFFF));
        x.wdata = 16'($urandom);
        x.alu   = 16'($urandom);
        x.rdst  = 3'($urandom);
        x.rw    = 1'($urandom);
        return x;
    endfunction

    // Reset asserted between edges; outputs must clear without a clock.
    task automatic async_reset();
        #2;
        ins0  = '0;
        ins1  = '0;
        rst_n = 1'b0;
        #1;
        check("rst_stall0", {31'd0, stall0}, 32'd0);
        check("rst_stall1", {31'd0, stall1}, 32'd0);
        check("rst_valid0", {31'd0, wb_valid0}, 32'd0);
        check("rst_valid1", {31'd0, wb_valid1}, 32'd0);
        check("rst_data0", {16'd0, wb_data0}, 32'd0);
        check("rst_data1", {16'd0, wb_data1}, 32'd0);
        check("rst_rd0", {29'd0, wb_rd0}, 32'd0);
        check("rst_rd1", {29'd0, wb_rd1}, 32'd0);
        check("rst_rw0", {31'd0, wb_reg_write0}, 32'd0);
        check("rst_rw1", {31'd0, wb_reg_write1}, 32'd0);
        check("rst_err0", {31'd0, addr_err0}, 32'd0);
        check("rst_err1", {31'd0, addr_err1}, 32'd0);
        @(negedge clk); cyc++;
        @(negedge clk); cyc++;
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            free_at[k]   = 0;
            due_at[k]    = -1;
            pend_rw[k]   = 1'b0;
            pend_err[k]  = 1'b0;
            last_data[k] = 16'h0000;
            last_rd[k]   = 3'd0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout exp=finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(negedge clk);
        async_reset();

        // Idle: nothing presented, nothing written back.
        for (int i = 0; i < 3; i++) step(0, '0);

        // Preload the working window in both memories.
        for (int d = 0; d < 2; d++) begin
            for (int a = 0; a < 64; a++)
                issue(d, mk(1'b0, 1'b1, 1'b0, 16'(a), 16'($urandom), 16'h0, 3'd0, 1'b0));
            issue(d, mk(1'b0, 1'b1, 1'b0, 16'h0FFF, 16'($urandom), 16'h0, 3'd0, 1'b0));
        end

        // Latency 1: store then load, then ALU op must not touch memory.
        issue(0, mk(1'b0, 1'b1, 1'b0, 16'h0010, 16'hBEEF, 16'h0, 3'd0, 1'b0));
        issue(0, mk(1'b1, 1'b0, 1'b1, 16'h0010, 16'h0, 16'h0, 3'd5, 1'b1));
        check("d0_load_beef", {16'd0, wb_data0}, 32'h0000BEEF);
        issue(0, mk(1'b0, 1'b0, 1'b0, 16'h0010, 16'h5555, 16'h1234, 3'd6, 1'b1));
        check("d0_alu_1234", {16'd0, wb_data0}, 32'h00001234);
        issue(0, mk(1'b1, 1'b0, 1'b1, 16'h0010, 16'h0, 16'h0, 3'd1, 1'b1));

        // Latency 3: load, with an ALU op waiting behind the stall.
        issue(1, mk(1'b0, 1'b1, 1'b0, 16'h0020, 16'h00A5, 16'h0, 3'd0, 1'b0));
        issue(1, mk(1'b1, 1'b0, 1'b1, 16'h0020, 16'h0, 16'h0, 3'd4, 1'b1));
        issue(1, mk(1'b0, 1'b0, 1'b0, 16'h0003, 16'h0, 16'h7777, 3'd2, 1'b1));
        step(1, '0);
        step(1, '0);

        // Out of range on both instances, then the word at 0 must be intact.
        for (int d = 0; d < 2; d++) begin
            issue(d, mk(1'b0, 1'b1, 1'b0, 16'h1000, 16'hFFFF, 16'h0, 3'd0, 1'b1));
            issue(d, mk(1'b1, 1'b0, 1'b1, 16'h1000, 16'h0, 16'h9999, 3'd2, 1'b1));
            issue(d, mk(1'b1, 1'b0, 1'b1, 16'h0000, 16'h0, 16'h0, 3'd3, 1'b1));
            for (int i = 0; i < 3; i++) step(d, '0);
        end

        // Reset during WAIT abandons the load.
        issue(1, mk(1'b1, 1'b0, 1'b1, 16'h0021, 16'h0, 16'h0, 3'd7, 1'b1));
        check("d1_stall_in_wait", {31'd0, stall1}, 32'd1);
        async_reset();
        for (int i = 0; i < 5; i++) step(1, '0);

        // Randomised traffic on both instances.
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 300; i++) begin
                instr_t x;
                x = rand_instr();
                if (x.valid) issue(d, x);
                else         step(d, x);
            end
            for (int i = 0; i < 4; i++) step(d, '0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_stage_param.md
Name: mem_stage_param

Overview:
- Parametrised successor to the single-cycle memory stage of the pipelined processor.
- Owns the data memory and the MEM/WB pipeline register, and performs the write-back select (memory read data vs ALU result).
- Adds a configurable read latency with a stall handshake, range checking with an error flag, and registered write-back outputs.
- Sits between the EX/MEM register and the register-file write port.

Parameters:
- DATA_W, 16, data/ALU word width in bits.
- ADDR_W, 16, address input width.
- DEPTH, 4096, number of memory words; legal addresses are 0..DEPTH-1; DEPTH <= 2^ADDR_W.
- READ_LAT, 1, load latency in cycles from acceptance to wb_valid; legal range 1..4.
- REG_W, 3, destination register index width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  EX/MEM holds a valid instruction.
- mem_read  in  1  load.
- mem_write  in  1  store.
- mem_to_reg  in  1  1 selects memory data for write-back, 0 selects alu_data.
- addr  in  ADDR_W  memory address.
- write_data  in  DATA_W  store data.
- alu_data  in  DATA_W  ALU result.
- rd_in  in  REG_W  destination register.
- reg_write_in  in  1  register-file write enable.
- stall  out  1  stage busy; upstream must hold all inputs.
- wb_valid  out  1  write-back outputs valid this cycle.
- wb_data  out  DATA_W  write-back data.
- wb_rd  out  REG_W  destination register.
- wb_reg_write  out  1  register-file write enable (already qualified with wb_valid).
- addr_err  out  1  one-cycle pulse: an accepted access was out of range.

Behaviour:
- Reset (rst_n low, asynchronous):
  - stall=0, wb_valid=0, wb_data=0, wb_rd=0, wb_reg_write=0, addr_err=0.
  - FSM goes to IDLE; latency counter is cleared.
  - Memory contents are not reset.
  - Reset mid-load abandons the load with no wb_valid; any store already accepted remains committed.
- Acceptance: an instruction is accepted on a rising edge where in_valid=1 and stall=0.
- FSM state IDLE:
  - stall=0.
  - Accepted non-load, or load with READ_LAT=1: registered outputs update on the same edge, giving wb_valid=1 for exactly one cycle (1-cycle latency).
  - Accepted load with READ_LAT>1: go to WAIT with cnt=READ_LAT-1; latch addr, rd_in, reg_write_in and mem_to_reg.
  - No acceptance: wb_valid=0 and wb_reg_write=0 next cycle; wb_data and wb_rd hold their previous values.
- FSM state WAIT:
  - stall=1, driven combinationally from state.
  - cnt decrements each edge. On the edge where cnt=1, the outputs load the latched result, wb_valid=1, and the FSM returns to IDLE.
  - All inputs are ignored in WAIT.
  - Result: wb_valid rises exactly READ_LAT edges after acceptance; stall is high for READ_LAT-1 cycles.
- Store: memory is written on the accepting edge when mem_write=1 and the address is in range.
  - The stage has no read-after-write bypass. A load accepted on a later edge to the same address returns the new data, because the write has already been committed.
- mem_read and mem_write both 1: treated as a store only (no load latency).
- wb_data select:
  - mem_to_reg=1 gives the memory read data.
  - mem_to_reg=0 gives alu_data as sampled at acceptance.
  - mem_to_reg with no mem_read returns the memory word at addr, with 1-cycle latency.
- wb_reg_write = reg_write_in as latched AND wb_valid.
- Out of range (addr >= DEPTH) with mem_read or mem_write set:
  - Stores are suppressed.
  - Load data is forced to 0.
  - addr_err pulses together with that instruction's wb_valid.
  - Timing is otherwise unchanged.
- Widths: addr compared zero-extended; memory index = addr[clog2(DEPTH)-1:0] once in range; no wrap-around.

Test Plan:
- Reset then idle -> all outputs 0 with rst_n asserted between edges (async); wb_valid stays 0 with in_valid=0.
- READ_LAT=1: store 0xBEEF @0x0010, then load with mem_to_reg=1 @0x0010, rd_in=5 -> next cycle wb_valid=1, wb_data=0xBEEF, wb_rd=5, wb_reg_write=1, stall never asserted.
- ALU op: alu_data=0x1234, mem_to_reg=0, reg_write_in=1 -> wb_data=0x1234 one cycle later; memory unchanged (load @ same addr returns prior value).
- READ_LAT=3: load @0x0020 holding 0x00A5 -> stall high 2 cycles; wb_valid exactly 3 edges after acceptance with 0x00A5; an instruction presented during stall is accepted only after stall drops.
- DEPTH=4096: store 0xFFFF @0x1000, then load @0x1000 -> addr_err pulses both times, load wb_data=0; word @0x0000 unchanged.
- READ_LAT=3: rst_n low during WAIT -> stall=0 and wb_valid=0 immediately; no late wb_valid after rst_n releases.
